// File: rtl/numarator_ture.sv
// numarator_ture: debounced lap counter with a two-digit BCD count, lap pulse and circuit target flag.
// Define NUMARATOR_TURE_HEX_EN to drive hex0/hex1 with 7-segment patterns; otherwise they stay blank.
module numarator_ture #(
   parameter int CLK_HZ       = 50000000,
   parameter int FILTRU_CICLI = 16,
   parameter int BLOCARE_MS   = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tact_count,
   input  logic       reset_count,
   input  logic [1:0] circuit,
   output logic [7:0] count_ture,
   output logic       puls_tura,
   output logic       depasire,
   output logic       limita_atinsa,
   output logic [6:0] hex0,
   output logic [6:0] hex1
);

   localparam int LOCK_CYC = CLK_HZ / 1000 * BLOCARE_MS;
   localparam int FILT_W   = (FILTRU_CICLI > 0) ? $clog2(FILTRU_CICLI + 1) : 1;
   localparam int LOCK_W   = (LOCK_CYC > 0) ? $clog2(LOCK_CYC + 1) : 1;

   localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTRU_CICLI);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYC);

   typedef enum logic [1:0] {
      ASTEPTARE,
      FILTRU,
      NUMARA,
      BLOCARE
   } state_t;

   state_t            state_q, state_d;
   logic              tact_s1_q, tact_s1_d;
   logic              s_tact_q, s_tact_d;
   logic              rst_s1_q, rst_s1_d;
   logic              s_rst_q, s_rst_d;
   logic [FILT_W-1:0] filt_q, filt_d;
   logic [LOCK_W-1:0] lock_q, lock_d;
   logic [7:0]        count_q, count_d;
   logic              puls_q, puls_d;
   logic              dep_q, dep_d;
   logic              s_tact;
   logic              s_rst;

   assign s_tact = s_tact_q;
   assign s_rst  = s_rst_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ASTEPTARE;
         tact_s1_q <= 1'b0;
         s_tact_q  <= 1'b0;
         rst_s1_q  <= 1'b0;
         s_rst_q   <= 1'b0;
         filt_q    <= '0;
         lock_q    <= '0;
         count_q   <= 8'h00;
         puls_q    <= 1'b0;
         dep_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tact_s1_q <= tact_s1_d;
         s_tact_q  <= s_tact_d;
         rst_s1_q  <= rst_s1_d;
         s_rst_q   <= s_rst_d;
         filt_q    <= filt_d;
         lock_q    <= lock_d;
         count_q   <= count_d;
         puls_q    <= puls_d;
         dep_q     <= dep_d;
      end
   end

   always_comb begin
      tact_s1_d = tact_count;
      s_tact_d  = tact_s1_q;
      rst_s1_d  = reset_count;
      s_rst_d   = rst_s1_q;
      state_d   = state_q;
      filt_d    = filt_q;
      lock_d    = lock_q;
      count_d   = count_q;
      puls_d    = 1'b0;
      dep_d     = dep_q;

      case (state_q)
         ASTEPTARE: begin
            filt_d = '0;
            lock_d = '0;
            if (s_tact) begin
               state_d = FILTRU;
               filt_d  = FILT_W'(1);
            end
         end

         FILTRU: begin
            if (!s_tact) begin
               state_d = ASTEPTARE;
               filt_d  = '0;
            end else if (filt_q >= FILT_MAX - FILT_W'(1)) begin
               state_d = NUMARA;
               filt_d  = FILT_MAX;
            end else begin
               filt_d = filt_q + FILT_W'(1);
            end
         end

         NUMARA: begin
            // Pulse is registered so it appears together with the new count.
            puls_d  = 1'b1;
            filt_d  = '0;
            lock_d  = '0;
            state_d = BLOCARE;
            if (count_q[3:0] == 4'd9) begin
               count_d[3:0] = 4'd0;
               if (count_q[7:4] == 4'd9) begin
                  count_d[7:4] = 4'd0;
                  dep_d        = 1'b1;
               end else begin
                  count_d[7:4] = count_q[7:4] + 4'd1;
               end
            end else begin
               count_d[3:0] = count_q[3:0] + 4'd1;
            end
         end

         BLOCARE: begin
            if (lock_q != LOCK_MAX) begin
               lock_d = lock_q + LOCK_W'(1);
            end else if (!s_tact) begin
               state_d = ASTEPTARE;
               lock_d  = '0;
            end
         end

         default: begin
            state_d = ASTEPTARE;
            filt_d  = '0;
            lock_d  = '0;
         end
      endcase

      // A lap-clear request overrides any lap being counted in the same cycle.
      if (s_rst) begin
         state_d = ASTEPTARE;
         filt_d  = '0;
         lock_d  = '0;
         count_d = 8'h00;
         puls_d  = 1'b0;
         dep_d   = 1'b0;
      end
   end

   always_comb begin
      limita_atinsa = 1'b0;
      case (circuit)
         2'b01:   limita_atinsa = (count_q != 8'h00);
         2'b10:   limita_atinsa = (count_q[7:4] != 4'd0);
         default: limita_atinsa = 1'b0;
      endcase
   end

   assign count_ture = count_q;
   assign puls_tura  = puls_q;
   assign depasire   = dep_q;

`ifdef NUMARATOR_TURE_HEX_EN
   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = 7'b1111111;
      endcase
      return pattern;
   endfunction

   always_comb begin
      hex0 = seg7(count_q[3:0]);
      hex1 = seg7(count_q[7:4]);
   end
`else
   assign hex0 = 7'b1111111;
   assign hex1 = 7'b1111111;
`endif

endmodule
